// File: rtl/dcache_controller.sv
// Direct-mapped, write-back / write-allocate data cache controller.
// Single outstanding CPU request; line transfers go to backing memory over a req/ack handshake.
module dcache_controller #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       is_input_valid,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [31:0]                addr,
    input  logic [31:0]                din,
    output logic                       is_ready,
    output logic                       is_output_valid,
    output logic [31:0]                dout,
    output logic                       is_hit,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [31:0]                dmem_addr,
    output logic [LINE_WORDS*32-1:0]   dmem_wdata,
    input  logic [LINE_WORDS*32-1:0]   dmem_rdata,
    input  logic                       dmem_ack,
    output logic [31:0]                hit_count,
    output logic [31:0]                miss_count
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int LINE_W = LINE_WORDS * 32;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] COMPARE    = 2'd1;
    localparam logic [1:0] WRITE_BACK = 2'd2;
    localparam logic [1:0] ALLOCATE   = 2'd3;

    logic [1:0]           state_q;
    logic [TAG_W-1:0]     req_tag_q;
    logic [IDX_W-1:0]     req_idx_q;
    logic [WORD_W-1:0]    req_word_q;
    logic [31:0]          req_din_q;
    logic                 req_store_q;
    logic                 first_q;
    logic                 dmem_req_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [31:0]          hit_count_q;
    logic [31:0]          miss_count_q;

    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]    data_mem [NUM_LINES];

    logic                 accept;
    logic                 lookup_hit;
    logic                 complete;
    logic                 mem_done;
    logic [TAG_W-1:0]     cur_tag;
    logic [LINE_W-1:0]    cur_line;
    logic [LINE_W-1:0]    store_line;
    logic [31:0]          rd_word;
    logic                 unused_addr_lsb;

    assign unused_addr_lsb = ^addr[1:0];

    assign accept     = (state_q == IDLE) && is_input_valid && (mem_read || mem_write);
    assign cur_tag    = tag_mem[req_idx_q];
    assign cur_line   = data_mem[req_idx_q];
    assign lookup_hit = valid_q[req_idx_q] && (cur_tag == req_tag_q);
    assign complete   = (state_q == COMPARE) && lookup_hit;
    // dmem_req_q is only ever set inside WRITE_BACK/ALLOCATE, so stray acks elsewhere are dropped
    assign mem_done   = dmem_req_q && dmem_ack;

    always_comb begin
        store_line = cur_line;
        rd_word    = '0;
        for (int unsigned w = 0; w < LINE_WORDS; w++) begin
            if (req_word_q == WORD_W'(w)) begin
                rd_word                = cur_line[w*32 +: 32];
                store_line[w*32 +: 32] = req_din_q;
            end
        end
    end

    always_comb begin
        dmem_addr  = '0;
        dmem_wdata = '0;
        if (state_q == WRITE_BACK) begin
            dmem_addr  = {cur_tag, req_idx_q, {OFF_W{1'b0}}};
            dmem_wdata = cur_line;
        end else if (state_q == ALLOCATE) begin
            dmem_addr  = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
        end
    end

    assign is_ready        = (state_q == IDLE);
    assign is_output_valid = complete;
    assign is_hit          = complete && first_q;
    assign dout            = (complete && !req_store_q) ? rd_word : '0;
    assign dmem_req        = dmem_req_q;
    assign dmem_we         = (state_q == WRITE_BACK);
    assign hit_count       = hit_count_q;
    assign miss_count      = miss_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_tag_q    <= '0;
            req_idx_q    <= '0;
            req_word_q   <= '0;
            req_din_q    <= '0;
            req_store_q  <= 1'b0;
            first_q      <= 1'b0;
            dmem_req_q   <= 1'b0;
            valid_q      <= '0;
            dirty_q      <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_tag_q   <= addr[31 -: TAG_W];
                        req_idx_q   <= addr[OFF_W +: IDX_W];
                        req_word_q  <= addr[2 +: WORD_W];
                        req_din_q   <= din;
                        req_store_q <= mem_write;
                        first_q     <= 1'b1;
                        state_q     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (lookup_hit) begin
                        if (req_store_q) begin
                            dirty_q[req_idx_q] <= 1'b1;
                        end
                        if (first_q) begin
                            hit_count_q <= hit_count_q + 32'd1;
                        end else begin
                            miss_count_q <= miss_count_q + 32'd1;
                        end
                        state_q <= IDLE;
                    end else begin
                        first_q <= 1'b0;
                        state_q <= (valid_q[req_idx_q] && dirty_q[req_idx_q]) ? WRITE_BACK : ALLOCATE;
                    end
                end
                // request rises one cycle after entry and drops for a cycle after each ack
                WRITE_BACK: begin
                    if (mem_done) begin
                        dmem_req_q <= 1'b0;
                        state_q    <= ALLOCATE;
                    end else begin
                        dmem_req_q <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (mem_done) begin
                        dmem_req_q         <= 1'b0;
                        valid_q[req_idx_q] <= 1'b1;
                        dirty_q[req_idx_q] <= 1'b0;
                        state_q            <= COMPARE;
                    end else begin
                        dmem_req_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; a reset forces IDLE so no write can occur while it is held.
    always_ff @(posedge clk) begin
        if ((state_q == ALLOCATE) && mem_done) begin
            data_mem[req_idx_q] <= dmem_rdata;
            tag_mem[req_idx_q]  <= req_tag_q;
        end else if (complete && req_store_q) begin
            data_mem[req_idx_q] <= store_line;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: a flat golden memory plus a tag map predict
// hits, line transfers and load data; a monitor and a memory responder check the DUT.
module tb_dcache_controller;

    typedef struct {
        logic [31:0] dout;
        logic        hit;
        int unsigned cyc;
    } rsp_t;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
    } mem_t;

    logic         clk;
    logic         rst_n;
    logic         is_input_valid;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  addr;
    logic [31:0]  din;
    logic         is_ready;
    logic         is_output_valid;
    logic [31:0]  dout;
    logic         is_hit;
    logic         dmem_req;
    logic         dmem_we;
    logic [31:0]  dmem_addr;
    logic [127:0] dmem_wdata;
    logic [127:0] dmem_rdata;
    logic         dmem_ack;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    dcache_controller #(.NUM_LINES(16), .LINE_WORDS(4)) dut (
        .clk(clk), .reset(rst_n),
        .is_input_valid(is_input_valid), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .din(din),
        .is_ready(is_ready), .is_output_valid(is_output_valid), .dout(dout), .is_hit(is_hit),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    rsp_t        sb [$];
    mem_t        mexp [$];
    logic [127:0] bmem [logic [31:0]];
    logic [31:0]  gold [logic [31:0]];
    logic         mvalid [16];
    logic         mdirty [16];
    logic [23:0]  mtag   [16];
    logic [31:0]  mhits;
    logic [31:0]  mmiss;
    logic         mem_auto = 1'b1;
    int           ack_delay = -1;
    int           pulses_wanted = 0;
    int           pulses_done   = 0;
    logic [23:0]  tags [4] = '{24'h000000, 24'h000011, 24'h0000A3, 24'hFFFFF0};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none (or bound expired)", name);
    endfunction

    function automatic logic [127:0] init_line(input logic [31:0] la);
        logic [127:0] l;
        logic [31:0]  x;
        l = '0;
        for (int w = 0; w < 4; w++) begin
            x = la + 32'(w * 4);
            l[w*32 +: 32] = (x * 32'h9E3779B9) ^ 32'h5A5A0F0F;
        end
        return l;
    endfunction

    function automatic logic [127:0] bmem_line(input logic [31:0] la);
        if (bmem.exists(la)) return bmem[la];
        return init_line(la);
    endfunction

    function automatic logic [31:0] gold_read(input logic [31:0] wa);
        logic [127:0] l;
        if (gold.exists(wa)) return gold[wa];
        l = bmem_line({wa[31:4], 4'b0});
        return l[int'(wa[3:2])*32 +: 32];
    endfunction

    function automatic logic [127:0] gold_line(input logic [31:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = gold_read(la + 32'(w * 4));
        return l;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
            mtag[i]   = '0;
        end
        mhits = '0;
        mmiss = '0;
        // dirty lines are dropped by reset, so only backing memory survives
        gold.delete();
    endfunction

    function automatic void model_accept(input logic store, input logic [31:0] a, input logic [31:0] d);
        int          idx;
        logic [23:0] tg;
        logic        hit;
        rsp_t        r;
        mem_t        m;
        idx = int'(a[7:4]);
        tg  = a[31:8];
        hit = mvalid[idx] && (mtag[idx] == tg);
        if (!hit) begin
            if (mvalid[idx] && mdirty[idx]) begin
                m.we    = 1'b1;
                m.addr  = {mtag[idx], a[7:4], 4'b0};
                m.wdata = gold_line(m.addr);
                mexp.push_back(m);
            end
            m.we    = 1'b0;
            m.addr  = {a[31:4], 4'b0};
            m.wdata = '0;
            mexp.push_back(m);
        end
        r.hit  = hit;
        r.dout = store ? 32'h0 : gold_read({a[31:2], 2'b0});
        r.cyc  = hit ? cyc + 1 : 0;
        sb.push_back(r);
        if (store) gold[{a[31:2], 2'b0}] = d;
        mdirty[idx] = (hit ? mdirty[idx] : 1'b0) | store;
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
        if (hit) mhits = mhits + 32'd1;
        else     mmiss = mmiss + 32'd1;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!is_ready && n < 200) begin
            is_input_valid = 1'($urandom);
            mem_read       = 1'($urandom);
            mem_write      = 1'($urandom);
            addr           = $urandom;
            din            = $urandom;
            @(posedge clk); #1;
            n++;
        end
        is_input_valid = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        if (!is_ready) flag("ready_timeout");
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        wait_ready();
        is_input_valid = 1'b1;
        mem_read       = rd;
        mem_write      = wr;
        addr           = a;
        din            = d;
        model_accept(wr, a, d);
        @(posedge clk); #1;
        is_input_valid = 1'b0;
        addr           = $urandom;
        din            = $urandom;
        wait_ready();
    endtask

    task automatic check_counts();
        chk("hit_count", hit_count, mhits);
        chk("miss_count", miss_count, mmiss);
    endtask

    // Output monitor
    rsp_t mon_e;
    always @(negedge clk) begin
        if (is_output_valid) begin
            if (sb.size() == 0) begin
                flag("unexpected_output_valid");
            end else begin
                mon_e = sb.pop_front();
                chk("dout", dout, mon_e.dout);
                chk("is_hit", is_hit, mon_e.hit);
                if (mon_e.cyc != 0) chk("hit_latency", cyc, mon_e.cyc);
            end
        end else begin
            chk("dout_idle_zero", dout, 0);
        end
    end

    // Backing-memory responder
    mem_t         rsp_m;
    logic         rsp_we;
    logic [31:0]  rsp_a;
    int           rsp_d;
    initial begin
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pulses_done != pulses_wanted) begin
                dmem_ack   = 1'b1;
                dmem_rdata = {$urandom, $urandom, $urandom, $urandom};
                @(negedge clk);
                dmem_ack = 1'b0;
                pulses_done++;
            end else if (mem_auto && rst_n && dmem_req) begin
                rsp_we = dmem_we;
                rsp_a  = dmem_addr;
                if (mexp.size() == 0) begin
                    flag("unexpected_dmem_req");
                end else begin
                    rsp_m = mexp.pop_front();
                    chk("dmem_we", rsp_we, rsp_m.we);
                    chk("dmem_addr", rsp_a, rsp_m.addr);
                    if (rsp_m.we) chk("dmem_wdata", dmem_wdata, rsp_m.wdata);
                end
                if (rsp_we) bmem[rsp_a] = dmem_wdata;
                rsp_d = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 3));
                for (int i = 0; i < rsp_d; i++) begin
                    @(negedge clk);
                    chk("dmem_req_hold", dmem_req, 1);
                    chk("dmem_we_hold", dmem_we, rsp_we);
                    chk("dmem_addr_hold", dmem_addr, rsp_a);
                    chk("busy_not_ready", is_ready, 0);
                end
                dmem_rdata = rsp_we ? {$urandom, $urandom, $urandom, $urandom} : bmem_line(rsp_a);
                dmem_ack   = 1'b1;
                @(negedge clk);
                dmem_ack   = 1'b0;
                dmem_rdata = {$urandom, $urandom, $urandom, $urandom};
                chk("dmem_req_drop", dmem_req, 0);
            end
        end
    end

    task automatic reset_during_allocate();
        int n;
        mem_auto = 1'b0;
        wait_ready();
        is_input_valid = 1'b1;
        mem_read       = 1'b1;
        mem_write      = 1'b0;
        addr           = 32'h0000_2094;
        model_accept(1'b0, 32'h0000_2094, 32'h0);
        @(posedge clk); #1;
        is_input_valid = 1'b0;
        n = 0;
        while (!dmem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("alloc_req_seen", dmem_req, 1);
        chk("alloc_we", dmem_we, 0);
        chk("alloc_addr", dmem_addr, 32'h0000_2090);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_dmem_req", dmem_req, 0);
        chk("rst_mid_dmem_we", dmem_we, 0);
        chk("rst_mid_ready", is_ready, 1);
        chk("rst_mid_out_valid", is_output_valid, 0);
        chk("rst_mid_hit_count", hit_count, 0);
        chk("rst_mid_miss_count", miss_count, 0);
        model_reset();
        sb.delete();
        mexp.delete();
        pulses_wanted++;
        n = 0;
        while (pulses_done != pulses_wanted && n < 10) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_first_cycle", is_ready, 1);
        pulses_wanted++;
        n = 0;
        while (pulses_done != pulses_wanted && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (pulses_done != pulses_wanted) flag("ack_pulse_timeout");
        @(negedge clk);
        chk("late_ack_no_req", dmem_req, 0);
        chk("late_ack_ready", is_ready, 1);
        mem_auto = 1'b1;
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 32'h0000_2094, 32'h0);
        chk("post_reset_miss_count", miss_count, 1);
        chk("post_reset_hit_count", hit_count, 0);
    endtask

    logic [31:0] ra;
    logic [3:0]  ri;
    logic [1:0]  rw;
    int          op;

    initial begin
        rst_n          = 1'b0;
        is_input_valid = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        addr           = '0;
        din            = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", is_ready, 1);
        chk("rst_out_valid", is_output_valid, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_dout", dout, 0);
        chk("rst_is_hit", is_hit, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", is_ready, 1);
        @(posedge clk); #1;

        bmem[32'h0000_0100] = {32'h0BAD_F00D, 32'hCAFE_0002, 32'hDEAD_BEEF, 32'h0000_1111};
        do_req(1'b1, 1'b0, 32'h0000_0104, 32'h0);
        chk("cold_miss_count", miss_count, 1);
        do_req(1'b1, 1'b0, 32'h0000_0104, 32'h0);
        chk("repeat_hit_count", hit_count, 1);
        do_req(1'b0, 1'b1, 32'h0000_0108, 32'h1234_5678);
        do_req(1'b1, 1'b0, 32'h0000_1108, 32'h0);
        chk("wb_hit_count", hit_count, 2);
        chk("wb_miss_count", miss_count, 2);
        check_counts();

        ack_delay = 10;
        do_req(1'b1, 1'b0, 32'h0000_3354, 32'h0);
        ack_delay = -1;
        check_counts();

        force dut.hit_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.hit_count_q;
        mhits = 32'hFFFF_FFFF;
        do_req(1'b1, 1'b0, 32'h0000_1108, 32'h0);
        chk("hit_count_wrap", hit_count, 0);
        check_counts();

        reset_during_allocate();

        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 9));
            ri = 4'($urandom_range(0, 15));
            rw = 2'($urandom_range(0, 3));
            ra = {tags[$urandom_range(0, 3)], ri, rw, 2'($urandom_range(0, 3))};
            if (op == 0) begin
                is_input_valid = 1'b1;
                mem_read       = 1'b0;
                mem_write      = 1'b0;
                addr           = ra;
                @(posedge clk); #1;
                is_input_valid = 1'b0;
                chk("nop_ignored", is_ready, 1);
            end else if (op <= 4) begin
                do_req(1'b1, 1'b0, ra, 32'h0);
            end else if (op <= 8) begin
                do_req(1'b0, 1'b1, ra, $urandom);
            end else begin
                do_req(1'b1, 1'b1, ra, $urandom);
            end
            if (n % 25 == 0) check_counts();
        end
        check_counts();

        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        chk("mem_queue_drained", mexp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL have parameter NUM_LINES, default 16, number of direct-mapped lines.
REQ-002 The block SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (128-bit line).
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port is_input_valid  input  1  CPU request present this cycle.
REQ-006 Port mem_read  input  1  request is a load.
REQ-007 Port mem_write  input  1  request is a store.
REQ-008 Port addr  input  32  byte address: tag [31:8], index [7:4], word [3:2], [1:0] ignored.
REQ-009 Port din  input  32  store data.
REQ-010 Port is_ready  output  1  controller can accept a request this cycle.
REQ-011 Port is_output_valid  output  1  one-cycle completion pulse.
REQ-012 Port dout  output  32  load data, valid only while is_output_valid=1.
REQ-013 Port is_hit  output  1  completed request hit on first lookup, valid with is_output_valid.
REQ-014 Port dmem_req  output  1  backing-memory request, held until dmem_ack.
REQ-015 Port dmem_we  output  1  1 = line write-back, 0 = line fill.
REQ-016 Port dmem_addr  output  32  line-aligned address, [3:0]=0.
REQ-017 Port dmem_wdata  output  128  victim line data.
REQ-018 Port dmem_rdata  input  128  fill data, sampled when dmem_ack=1.
REQ-019 Port dmem_ack  input  1  one-cycle memory completion pulse.
REQ-020 Port hit_count, miss_count  output  32 each  completed-request statistics.

Function
REQ-021 Storage SHALL be internal: per line valid, dirty, 24-bit tag, 128-bit data; write-back, write-allocate.
REQ-022 FSM states SHALL be IDLE, COMPARE, WRITE_BACK, ALLOCATE.
REQ-023 is_ready SHALL be 1 only in IDLE; a request is accepted when is_ready & is_input_valid & (mem_read | mem_write), latching addr, din, and read/write type.
REQ-024 In IDLE, is_input_valid with neither mem_read nor mem_write SHALL be ignored.
REQ-025 Inputs while is_ready=0 SHALL be ignored; the latched request drives all later behaviour.
REQ-026 COMPARE, hit (valid & tag match): pulse is_output_valid that cycle; load: dout = selected word; store: write word, set dirty; return to IDLE (hit latency = 1 cycle after acceptance).
REQ-027 COMPARE, miss with dirty victim -> WRITE_BACK; miss with clean or invalid victim -> ALLOCATE.
REQ-028 WRITE_BACK: dmem_req=1, dmem_we=1, dmem_addr={victim tag, index, 4'b0}, dmem_wdata=victim line; on dmem_ack -> ALLOCATE.
REQ-029 ALLOCATE: dmem_req=1, dmem_we=0, dmem_addr={req tag, index, 4'b0}; on dmem_ack write dmem_rdata to line, set valid, clear dirty, set tag, -> COMPARE.
REQ-030 dmem_req SHALL be asserted the cycle after entering WRITE_BACK or ALLOCATE, held stable until dmem_ack, and deasserted the cycle after dmem_ack; dmem_ack outside these states SHALL be ignored.
REQ-031 is_hit SHALL be 1 only if the first COMPARE of the request hit; the post-fill COMPARE SHALL report is_hit=0.
REQ-032 On each is_output_valid, hit_count or miss_count SHALL increment by 1, wrapping modulo 2^32.
REQ-033 is_output_valid SHALL be high exactly one cycle per accepted request; dout SHALL be 0 when not valid.
REQ-034 Both mem_read and mem_write set SHALL be treated as a store.

Reset
REQ-035 Reset low SHALL immediately force IDLE, clear all valid and dirty bits, zero hit_count and miss_count, and drive dmem_req=0, dmem_we=0, is_output_valid=0, is_hit=0, dout=0; data and tag storage need not be cleared.
REQ-036 Reset asserted mid-WRITE_BACK or mid-ALLOCATE SHALL abandon the transfer; a dmem_ack arriving after reset SHALL be ignored.
REQ-037 is_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-038 Cold load addr 0x0000_0104 -> ALLOCATE dmem_addr 0x0000_0100, ack with rdata word1=0xDEADBEEF -> dout 0xDEADBEEF, is_hit 0, miss_count 1.
REQ-039 Repeat load 0x0000_0104 -> is_output_valid exactly 1 cycle after acceptance, is_hit 1, no dmem_req, hit_count 1.
REQ-040 Store 0x1234_5678 to 0x0000_0108 (hit), then load 0x0000_1108 (same index, new tag) -> WRITE_BACK to 0x0000_0100 with wdata word2=0x1234_5678, then ALLOCATE at 0x0000_1100.
REQ-041 dmem_ack delayed 10 cycles -> dmem_req, dmem_we, dmem_addr stable all 10 cycles; is_ready 0 throughout; extra is_input_valid pulses ignored.
REQ-042 Reset low during ALLOCATE, then ack pulse -> state IDLE, dmem_req 0, counters 0, next load to same address misses.
REQ-043 hit_count preloaded to 0xFFFF_FFFF via repeated hits (or force) plus one hit -> wraps to 0.
